// File: rtl/lc3b_types.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lc3b_types : shared L2 controller types (FSM state, PLRU sizing helper)
// Rev 1.0
// ----------------------------------------------------------------------------
package lc3b_types;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WB      = 3'd1,
      ST_FILL    = 3'd2,
      ST_REPLAY  = 3'd3,
      ST_WAROUND = 3'd4
   } l2_state_t;

   // A binary PLRU tree over WAYS leaves holds WAYS-1 node bits.
   function automatic int plru_width(input int ways);
      return ways - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plru_tree : tree-PLRU victim select and touch update (combinational)
// Rev 1.0
// ----------------------------------------------------------------------------
module plru_tree import lc3b_types::*; #(
   parameter int WAYS = 4
) (
   input  logic [plru_width(WAYS)-1:0] plru_bits,
   input  logic [$clog2(WAYS)-1:0]     touch_way,
   output logic [$clog2(WAYS)-1:0]     victim,
   output logic [plru_width(WAYS)-1:0] plru_next
);

   localparam int c_log       = $clog2(WAYS);
   localparam int c_leaf_base_i = WAYS - 1;
   localparam logic [c_log:0] c_leaf_base = c_leaf_base_i[c_log:0];
   localparam logic [c_log:0] c_one       = {{c_log{1'b0}}, 1'b1};

   // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 1 points right.
   logic [WAYS-1:0] w_tree_in;
   logic [WAYS-1:0] w_tree_out;
   logic [c_log:0]  w_walk;
   logic [c_log:0]  w_leaf;
   logic [c_log:0]  w_up;
   logic [c_log:0]  w_parent;
   logic            w_unused;

   assign w_tree_in = {1'b0, plru_bits};

   always_comb begin
      w_walk = '0;
      for (int l = 0; l < c_log; l++)
         w_walk = {w_walk[c_log-1:0], 1'b0} + c_one
                + {{c_log{1'b0}}, w_tree_in[w_walk[c_log-1:0]]};
      w_leaf = w_walk - c_leaf_base;
   end

   assign victim = w_leaf[c_log-1:0];

   // Walk from the touched leaf to the root, pointing every node away from it.
   always_comb begin
      w_tree_out = w_tree_in;
      w_up       = {1'b0, touch_way} + c_leaf_base;
      w_parent   = '0;
      for (int l = 0; l < c_log; l++) begin
         w_parent = (w_up - c_one) >> 1;
         w_tree_out[w_parent[c_log-1:0]] = w_up[0];
         w_up = w_parent;
      end
   end

   assign plru_next = w_tree_out[WAYS-2:0];
   assign w_unused  = ^{w_tree_out[WAYS-1], w_leaf[c_log]};

endmodule
`default_nettype wire

// File: rtl/l2_cache_ctrl_nway.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l2_cache_ctrl_nway : N-way write-back L2 control FSM with tree-PLRU and counters
// Rev 1.0
// ----------------------------------------------------------------------------
module l2_cache_ctrl_nway import lc3b_types::*; #(
   parameter int WAYS        = 4,
   parameter bit WRITE_ALLOC = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cache_read,
   input  logic                        cache_write,
   input  logic [WAYS-1:0]             hit_vec,
   input  logic [WAYS-1:0]             valid_vec,
   input  logic [WAYS-1:0]             dirty_vec,
   input  logic [plru_width(WAYS)-1:0] plru_bits,
   input  logic                        mem_resp,
   output logic                        cache_resp,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic                        mem_addr_sel,
   output logic                        data_sel,
   output logic [WAYS-1:0]             load_way,
   output logic                        load_tag,
   output logic [WAYS-1:0]             load_dirty,
   output logic                        dirty_in,
   output logic                        load_plru,
   output logic [plru_width(WAYS)-1:0] plru_next,
   output logic [$clog2(WAYS)-1:0]     victim_way,
   output logic [CNT_W-1:0]            hit_count,
   output logic [CNT_W-1:0]            miss_count,
   output logic [CNT_W-1:0]            wb_count
);

   localparam int c_idx_w = $clog2(WAYS);
   localparam logic [WAYS-1:0]  c_way_one = {{(WAYS-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   l2_state_t          r_state, w_next_state;
   logic [c_idx_w-1:0] r_victim;
   logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt, r_wb_cnt;

   logic [c_idx_w-1:0] w_hit_idx, w_inv_idx, w_plru_victim, w_miss_victim;
   logic [WAYS-1:0]    w_hit_oh, w_victim_oh;
   logic               w_req, w_is_write, w_hit, w_inv_any, w_victim_dirty;
   logic               w_victim_latch, w_hit_inc, w_miss_inc, w_wb_inc;

   assign w_req      = cache_read | cache_write;
   assign w_is_write = cache_write & ~cache_read;
   assign w_hit      = |hit_vec;
   assign w_inv_any  = ~&valid_vec;

   // Lowest-index hit way and lowest-index invalid way.
   always_comb begin
      w_hit_idx = '0;
      w_inv_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit_vec[i])    w_hit_idx = c_idx_w'(i);
         if (!valid_vec[i]) w_inv_idx = c_idx_w'(i);
      end
   end

   plru_tree #(.WAYS(WAYS)) u_plru (
      .plru_bits (plru_bits),
      .touch_way (w_hit_idx),
      .victim    (w_plru_victim),
      .plru_next (plru_next)
   );

   assign w_miss_victim  = w_inv_any ? w_inv_idx : w_plru_victim;
   assign w_victim_dirty = valid_vec[w_miss_victim] & dirty_vec[w_miss_victim];
   assign w_hit_oh       = c_way_one << w_hit_idx;
   assign w_victim_oh    = c_way_one << r_victim;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_victim   <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_wb_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_victim_latch) r_victim <= w_miss_victim;
         if (w_hit_inc  && !(&r_hit_cnt))  r_hit_cnt  <= r_hit_cnt  + c_cnt_one;
         if (w_miss_inc && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + c_cnt_one;
         if (w_wb_inc   && !(&r_wb_cnt))   r_wb_cnt   <= r_wb_cnt   + c_cnt_one;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      cache_resp     = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_addr_sel   = 1'b0;
      data_sel       = 1'b0;
      load_way       = '0;
      load_tag       = 1'b0;
      load_dirty     = '0;
      dirty_in       = 1'b0;
      load_plru      = 1'b0;
      w_victim_latch = 1'b0;
      w_hit_inc      = 1'b0;
      w_miss_inc     = 1'b0;
      w_wb_inc       = 1'b0;

      if (!reset) begin
         case (r_state)
            ST_IDLE: begin
               if (w_req && w_hit) begin
                  cache_resp = 1'b1;
                  load_plru  = 1'b1;
                  w_hit_inc  = 1'b1;
                  if (w_is_write) begin
                     load_way   = w_hit_oh;
                     load_dirty = w_hit_oh;
                     dirty_in   = 1'b1;
                  end
               end else if (w_req) begin
                  w_miss_inc = 1'b1;
                  if (w_is_write && !WRITE_ALLOC) begin
                     w_next_state = ST_WAROUND;
                  end else begin
                     w_victim_latch = 1'b1;
                     w_next_state   = w_victim_dirty ? ST_WB : ST_FILL;
                  end
               end
            end
            ST_WB: begin
               mem_write    = 1'b1;
               mem_addr_sel = 1'b1;
               if (mem_resp) begin
                  load_dirty   = w_victim_oh;
                  w_wb_inc     = 1'b1;
                  w_next_state = ST_FILL;
               end
            end
            ST_FILL: begin
               mem_read = 1'b1;
               if (mem_resp) begin
                  load_way     = w_victim_oh;
                  load_tag     = 1'b1;
                  load_dirty   = w_victim_oh;
                  data_sel     = 1'b1;
                  w_next_state = ST_REPLAY;
               end
            end
            ST_REPLAY: begin
               // A missing hit here means the fill did not land; drop back quietly.
               w_next_state = ST_IDLE;
               if (w_hit) begin
                  cache_resp = 1'b1;
                  load_plru  = 1'b1;
                  if (w_is_write) begin
                     load_way   = w_hit_oh;
                     load_dirty = w_hit_oh;
                     dirty_in   = 1'b1;
                  end
               end
            end
            ST_WAROUND: begin
               mem_write = 1'b1;
               if (mem_resp) begin
                  cache_resp   = 1'b1;
                  w_next_state = ST_IDLE;
               end
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   assign victim_way = r_victim;
   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
   assign wb_count   = r_wb_cnt;

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_ctrl_nway.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_l2_cache_ctrl_nway : directed bench for l2_cache_ctrl_nway (WAYS=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_l2_cache_ctrl_nway;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, rd0, wr0, rd1, wr1, mem_resp;
   logic [3:0] hit_vec, valid_vec, dirty_vec;
   logic [2:0] plru_bits;

   logic        cache_resp, mem_read, mem_write, mem_addr_sel, data_sel, load_tag, dirty_in, load_plru;
   logic [3:0]  load_way, load_dirty;
   logic [2:0]  plru_next;
   logic [1:0]  victim_way;
   logic [31:0] hit_count, miss_count, wb_count;

   logic        a_cache_resp, a_mem_read, a_mem_write, a_mem_addr_sel, a_data_sel, a_load_tag, a_dirty_in, a_load_plru;
   logic [3:0]  a_load_way, a_load_dirty;
   logic [2:0]  a_plru_next;
   logic [1:0]  a_victim_way;
   logic [1:0]  a_hit_count, a_miss_count, a_wb_count;

   int n_checks = 0;
   int n_errors = 0;

   l2_cache_ctrl_nway #(.WAYS(4), .WRITE_ALLOC(1'b1), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .cache_read(rd0), .cache_write(wr0),
      .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_bits(plru_bits),
      .mem_resp(mem_resp), .cache_resp(cache_resp), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr_sel(mem_addr_sel), .data_sel(data_sel), .load_way(load_way), .load_tag(load_tag),
      .load_dirty(load_dirty), .dirty_in(dirty_in), .load_plru(load_plru), .plru_next(plru_next),
      .victim_way(victim_way), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   // Write-around variant with narrow counters for saturation.
   l2_cache_ctrl_nway #(.WAYS(4), .WRITE_ALLOC(1'b0), .CNT_W(2)) dut_wa (
      .clk(clk), .reset(reset), .cache_read(rd1), .cache_write(wr1),
      .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_bits(plru_bits),
      .mem_resp(mem_resp), .cache_resp(a_cache_resp), .mem_read(a_mem_read), .mem_write(a_mem_write),
      .mem_addr_sel(a_mem_addr_sel), .data_sel(a_data_sel), .load_way(a_load_way), .load_tag(a_load_tag),
      .load_dirty(a_load_dirty), .dirty_in(a_dirty_in), .load_plru(a_load_plru), .plru_next(a_plru_next),
      .victim_way(a_victim_way), .hit_count(a_hit_count), .miss_count(a_miss_count), .wb_count(a_wb_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; rd0 = 1'b1; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; mem_resp = 1'b0;
      hit_vec = 4'b0001; valid_vec = 4'b0000; dirty_vec = 4'b0000; plru_bits = 3'b000;
      #2;
      check("rst_resp", cache_resp, 1'b0);
      check("rst_plru", load_plru, 1'b0);
      tick; tick;
      check("rst_hit_cnt", hit_count, 32'd0);
      check("rst_miss_cnt", miss_count, 32'd0);
      check("rst_wb_cnt", wb_count, 32'd0);
      check("rst_victim", victim_way, 2'd0);

      // 1: read miss, all invalid -> way 0, FILL, REPLAY
      reset = 1'b0; hit_vec = 4'b0000; #1;
      check("t1_idle_resp", cache_resp, 1'b0);
      check("t1_idle_mrd", mem_read, 1'b0);
      tick;
      check("t1_miss_cnt", miss_count, 32'd1);
      check("t1_victim", victim_way, 2'd0);
      check("t1_fill_mrd", mem_read, 1'b1);
      check("t1_fill_sel", mem_addr_sel, 1'b0);
      check("t1_fill_mwr", mem_write, 1'b0);
      tick;
      check("t1_fill_wait", mem_read, 1'b1);
      mem_resp = 1'b1; #1;
      check("t1_fill_lway", load_way, 4'b0001);
      check("t1_fill_ltag", load_tag, 1'b1);
      check("t1_fill_dsel", data_sel, 1'b1);
      check("t1_fill_ldirty", load_dirty, 4'b0001);
      check("t1_fill_din", dirty_in, 1'b0);
      check("t1_fill_resp", cache_resp, 1'b0);
      tick;
      mem_resp = 1'b0; hit_vec = 4'b0001; valid_vec = 4'b0001; #1;
      check("t1_rep_resp", cache_resp, 1'b1);
      check("t1_rep_lplru", load_plru, 1'b1);
      check("t1_rep_plru", plru_next, 3'b011);
      check("t1_rep_lway", load_way, 4'b0000);
      tick;
      check("t1_hit_cnt", hit_count, 32'd0);
      check("t1_miss_cnt2", miss_count, 32'd1);

      // 2: read hit, write hit, read+write treated as read
      plru_bits = 3'b011; #1;
      check("t2_resp", cache_resp, 1'b1);
      check("t2_plru", plru_next, 3'b011);
      check("t2_mrd", mem_read, 1'b0);
      tick;
      check("t2_hit_cnt", hit_count, 32'd1);
      rd0 = 1'b0; wr0 = 1'b1; hit_vec = 4'b0100; valid_vec = 4'b0101; #1;
      check("t2w_lway", load_way, 4'b0100);
      check("t2w_ldirty", load_dirty, 4'b0100);
      check("t2w_din", dirty_in, 1'b1);
      check("t2w_dsel", data_sel, 1'b0);
      check("t2w_plru", plru_next, 3'b110);
      check("t2w_resp", cache_resp, 1'b1);
      tick;
      check("t2w_hit_cnt", hit_count, 32'd2);
      rd0 = 1'b1; hit_vec = 4'b0010; plru_bits = 3'b110; valid_vec = 4'b0111; #1;
      check("t2rw_lway", load_way, 4'b0000);
      check("t2rw_plru", plru_next, 3'b101);
      check("t2rw_resp", cache_resp, 1'b1);
      tick;
      check("t2rw_hit_cnt", hit_count, 32'd3);

      // 3: full set, PLRU picks dirty way 2 -> WB then FILL
      wr0 = 1'b0; hit_vec = 4'b0000; valid_vec = 4'b1111; dirty_vec = 4'b0100; plru_bits = 3'b001; #1;
      check("t3_idle_resp", cache_resp, 1'b0);
      check("t3_idle_mwr", mem_write, 1'b0);
      tick;
      check("t3_victim", victim_way, 2'd2);
      check("t3_miss_cnt", miss_count, 32'd2);
      check("t3_wb_mwr", mem_write, 1'b1);
      check("t3_wb_sel", mem_addr_sel, 1'b1);
      check("t3_wb_mrd", mem_read, 1'b0);
      mem_resp = 1'b1; #1;
      check("t3_wb_ldirty", load_dirty, 4'b0100);
      check("t3_wb_din", dirty_in, 1'b0);
      check("t3_wb_lway", load_way, 4'b0000);
      tick;
      mem_resp = 1'b0; #1;
      check("t3_wb_cnt", wb_count, 32'd1);
      check("t3_fill_mrd", mem_read, 1'b1);
      check("t3_fill_mwr", mem_write, 1'b0);
      check("t3_fill_sel", mem_addr_sel, 1'b0);
      mem_resp = 1'b1; #1;
      check("t3_fill_lway", load_way, 4'b0100);
      check("t3_fill_ltag", load_tag, 1'b1);
      tick;
      mem_resp = 1'b0; hit_vec = 4'b0100; dirty_vec = 4'b0000; #1;
      check("t3_rep_resp", cache_resp, 1'b1);
      check("t3_rep_plru", plru_next, 3'b100);
      tick;
      check("t3_hit_cnt", hit_count, 32'd3);

      // invalid-first beats a dirty PLRU victim; 5: reset during FILL with mem_resp
      hit_vec = 4'b0000; valid_vec = 4'b1101; dirty_vec = 4'b1111; plru_bits = 3'b000; #1;
      tick;
      check("t5_victim", victim_way, 2'd1);
      check("t5_fill_mrd", mem_read, 1'b1);
      check("t5_fill_mwr", mem_write, 1'b0);
      check("t5_miss_cnt", miss_count, 32'd3);
      mem_resp = 1'b1; reset = 1'b1; #1;
      check("t5_rst_mrd", mem_read, 1'b0);
      check("t5_rst_lway", load_way, 4'b0000);
      check("t5_rst_ltag", load_tag, 1'b0);
      check("t5_rst_resp", cache_resp, 1'b0);
      tick;
      check("t5_miss_cnt0", miss_count, 32'd0);
      check("t5_hit_cnt0", hit_count, 32'd0);
      check("t5_wb_cnt0", wb_count, 32'd0);
      check("t5_victim0", victim_way, 2'd0);
      reset = 1'b0; mem_resp = 1'b0; rd0 = 1'b0; #1;
      check("t5_idle_mrd", mem_read, 1'b0);
      tick;
      check("t5_idle_mrd2", mem_read, 1'b0);

      // 4: WRITE_ALLOC=0 write miss -> WAROUND
      wr1 = 1'b1; hit_vec = 4'b0000; valid_vec = 4'b0001; dirty_vec = 4'b0000; #1;
      check("t4_idle_mwr", a_mem_write, 1'b0);
      tick;
      check("t4_wa_mwr", a_mem_write, 1'b1);
      check("t4_wa_sel", a_mem_addr_sel, 1'b0);
      check("t4_wa_lway", a_load_way, 4'b0000);
      check("t4_wa_resp", a_cache_resp, 1'b0);
      check("t4_miss_cnt", a_miss_count, 2'd1);
      tick;
      check("t4_wa_wait", a_mem_write, 1'b1);
      mem_resp = 1'b1; #1;
      check("t4_wa_done_resp", a_cache_resp, 1'b1);
      check("t4_wa_done_lway", a_load_way, 4'b0000);
      check("t4_wa_done_ltag", a_load_tag, 1'b0);
      tick;
      mem_resp = 1'b0; #1;
      check("t4_victim_kept", a_victim_way, 2'd0);
      check("t4_back_idle", a_mem_write, 1'b0);

      // 6: miss counter saturates at all-ones
      for (int k = 1; k <= 3; k++) begin
         tick;
         check($sformatf("t6_miss_cnt_%0d", k), a_miss_count, (k == 1) ? 2'd2 : 2'd3);
         mem_resp = 1'b1;
         tick;
         mem_resp = 1'b0;
      end
      wr1 = 1'b0;
      check("t6_main_undisturbed", miss_count, 32'd0);
      check("t6_wb_cnt", a_wb_count, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
